// File: rtl/gate_op_scheduler_pkg.sv
// Shared opcode encoding and bitwise evaluation for the gate operation scheduler.
package gate_ops_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } op_e;

  localparam int NUM_OPS = 8;
  localparam int OP_W    = $clog2(NUM_OPS);
  localparam int MAX_W   = 64;

  // Operands wider than the caller needs are zero-extended; callers truncate the result.
  function automatic logic [MAX_W-1:0] eval(op_e op, logic [MAX_W-1:0] a, logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] res;
    res = a;
    unique case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_NOT:  res = ~a;
      OP_BUF:  res = a;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_op_scheduler_if.sv
// Request/response bundle between gate-level clients and the shared evaluation unit.
interface gate_op_scheduler_if
  import gate_ops_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*OP_W-1:0] req_op;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [WIDTH-1:0]        rsp_data;
  logic [ID_W-1:0]         rsp_id;
  logic [OP_W-1:0]         rsp_op;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_op
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_op
  );

endinterface

// File: rtl/gate_op_scheduler_arbiter.sv
// Combinational round-robin picker: first requester after ptr (with wrap) wins.
module gate_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (enable && !found && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = ID_W'(cand);
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_op_scheduler.sv
// Round-robin shared logic unit: one issue per cycle, one-cycle registered result, full backpressure.
module gate_op_scheduler
  import gate_ops_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic                clk,
  input logic                rst_n,
  gate_op_scheduler_if.slave bus
);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               slot_free;
  logic               any_grant;
  op_e                op_sel;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;

  logic               held_valid;
  logic [WIDTH-1:0]   held_data;
  logic [ID_W-1:0]    held_id;
  logic [OP_W-1:0]    held_op;

  // The output slot can take a new result when empty or being drained this cycle.
  assign slot_free = !held_valid || bus.rsp_ready;

  gate_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (bus.req_valid),
    .enable (slot_free && rst_n),
    .ptr    (ptr),
    .grant  (grant),
    .idx    (grant_idx)
  );

  assign any_grant     = |grant;
  assign bus.req_ready = grant;

  assign op_sel = op_e'(bus.req_op[int'(grant_idx)*OP_W +: OP_W]);
  assign a_sel  = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign b_sel  = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];

  // A grant always wins over a plain drain, so drain+accept keeps the slot full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_valid <= 1'b0;
      held_data  <= '0;
      held_id    <= '0;
      held_op    <= '0;
      ptr        <= ID_W'(NUM_REQ - 1);
    end else if (any_grant) begin
      held_valid <= 1'b1;
      held_data  <= WIDTH'(eval(op_sel, MAX_W'(a_sel), MAX_W'(b_sel)));
      held_id    <= grant_idx;
      held_op    <= op_sel;
      ptr        <= grant_idx;
    end else if (bus.rsp_ready) begin
      held_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid = held_valid;
  assign bus.rsp_data  = held_data;
  assign bus.rsp_id    = held_id;
  assign bus.rsp_op    = held_op;

endmodule

// File: doc/gate_op_scheduler.md
Name: gate_op_scheduler

Overview:
- Shares one registered multi-function logic unit (AND, OR, NAND, NOR, XOR, XNOR, NOT, BUF, bitwise over WIDTH bits) between NUM_REQ requesters.
- Round-robin arbitration, valid/ready handshakes on every requester port and on the single response port.
- Sits between gate-level client blocks and the shared evaluation datapath. One issue per cycle, one-cycle latency, full backpressure.

Parameters:
- WIDTH, 4, operand/result width in bits (>=1)
- NUM_REQ, 3, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ), width of the requester index on the response

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- req_valid  input  NUM_REQ  per-requester request valid
- req_op  input  NUM_REQ*3  per-requester opcode (gate_ops_pkg::op_e), slice i = [3i+2:3i]
- req_a  input  NUM_REQ*WIDTH  per-requester operand A
- req_b  input  NUM_REQ*WIDTH  per-requester operand B (ignored for NOT/BUF)
- req_ready  output  NUM_REQ  one-hot-or-zero grant; transfer on req_valid[i]&req_ready[i]
- rsp_valid  output  1  response valid
- rsp_ready  input  1  consumer ready
- rsp_data  output  WIDTH  result
- rsp_id  output  ID_W  index of requester that issued the result
- rsp_op  output  3  opcode that produced the result

Behaviour:
- Reset (rst_n low at a clk edge): rsp_valid=0, rsp_data=0, rsp_id=0, rsp_op=0, rr pointer = NUM_REQ-1, so requester 0 has top priority on the first arbitration. req_ready=0 while rst_n low.
- slot_free = !rsp_valid | rsp_ready. It is combinational.
- Arbitration is combinational:
  - If slot_free, grant the first i with req_valid[i]=1, searching from (ptr+1) mod NUM_REQ upward with wrap.
  - req_ready[i]=1 only for that i. req_ready=0 when !slot_free or no valid.
  - req_ready never depends on req_op or on operand data.
- Accept at edge:
  - On a grant, register rsp_data=eval(op,a,b), rsp_id=i, rsp_op=op, rsp_valid=1, ptr=i.
  - Latency: request accepted at edge N gives rsp_valid high after edge N, visible in cycle N+1.
- Drain without accept: if rsp_valid&rsp_ready and no grant, rsp_valid clears. Data/id/op hold their last values.
- Stall: while rsp_valid&!rsp_ready, rsp_data/rsp_id/rsp_op/rsp_valid hold stable and ptr holds.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one and rsp_valid stays 1. Full throughput is one result per cycle.
- Operation results, bitwise over WIDTH:
  - AND a&b, OR a|b, NAND ~(a&b), NOR ~(a|b), XOR a^b, XNOR ~(a^b), NOT ~a, BUF a.
  - No carry and no width growth. All 8 encodings are legal.
- Fairness: a requester holding req_valid continuously is granted within NUM_REQ accepts. Requesters with req_valid low are skipped with no idle cycle.
- Requester obligations (checked by the bench, not by RTL): once asserted, req_valid/op/a/b hold until accepted.
- Reset mid-operation overrides any pending transfer. A held response is discarded, not delivered.
- State machine (implicit in rsp_valid):
  - EMPTY -> FULL on grant.
  - FULL -> FULL on stall, or on drain+grant.
  - FULL -> EMPTY on drain without grant.

Decomposition:
- Package gate_ops_pkg holds:
  - typedef enum logic [2:0] op_e {OP_AND=0, OP_OR=1, OP_NAND=2, OP_NOR=3, OP_XOR=4, OP_XNOR=5, OP_NOT=6, OP_BUF=7}
  - localparam NUM_OPS=8
  - function eval(op, a, b), parameterised by width through a parameterised class or a fixed max width with masking.
- Sub-module gate_rr_arbiter (NUM_REQ) holds:
  - req vector, enable (slot_free), ptr in; one-hot grant and encoded index out.
  - It is purely combinational. ptr stays in the top level.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_data=0. After release, the first grant goes to requester 0.
- Single AND, WIDTH=4: req0 op=AND a=4'b1100 b=4'b1010 -> next cycle rsp_valid=1, rsp_data=4'b1000, rsp_id=0, rsp_op=0. Then XNOR on the same operands -> 4'b1001.
- NOT/BUF ignore b: req1 op=NOT a=4'b0101 b=4'b1111 -> rsp_data=4'b1010, rsp_id=1. Then BUF a=4'b0011 -> 4'b0011.
- Round-robin, all three valid, rsp_ready=1 -> grant order 0,1,2,0,1,2 with rsp_valid high every cycle and no bubbles. With req1 never valid the order is 0,2,0,2.
- Backpressure: rsp_ready=0 for 5 cycles with result 4'b0110 held -> rsp_* stable and req_ready=0 throughout. When rsp_ready rises, the next request is granted in that same cycle and a new result appears the following cycle.
- Reset mid-operation: drive rst_n=0 at an edge while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 after that edge, the held result is never delivered, and requester 0 has priority again.
